// File: rtl/uart_rx_fifo_param_if.sv
// Host-side read port of uart_rx_fifo_param.
//   read_req         : pop the head entry (master -> slave)
//   read_data        : head entry, first-word-fall-through (slave -> master)
//   rx_fifo_capacity : number of entries held
//   rx_empty/rx_full : FIFO occupancy flags
// Handshake: read_data is valid whenever rx_empty = 0. A pop happens on a
// clk edge where read_req = 1 and rx_empty = 0; read_req while empty is
// ignored. The next entry appears on read_data in the following cycle.
interface uart_rx_fifo_param_if #(
  parameter int DATA_BITS = 8,
  parameter int LOG_DEPTH = 4
);
  logic                 read_req;
  logic [DATA_BITS-1:0] read_data;
  logic [LOG_DEPTH:0]   rx_fifo_capacity;
  logic                 rx_empty;
  logic                 rx_full;

  modport master (
    output read_req,
    input  read_data, rx_fifo_capacity, rx_empty, rx_full
  );

  modport slave (
    input  read_req,
    output read_data, rx_fifo_capacity, rx_empty, rx_full
  );
endinterface

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver with a receive FIFO, single clock domain.
// Ports:
//   clk, reset     : system clock, asynchronous active-low reset
//   baud_div       : oversample tick period minus 1, in clk cycles
//   rx             : asynchronous serial line, idle high
//   clear_err      : one-cycle pulse clearing the sticky flags
//   frame_err, parity_err, overrun_err, break_det : sticky error flags
//   dbg_state_o    : current receiver FSM state (IDLE=0 START=1 DATA=2
//                    PARITY=3 STOP=4)
//   host           : FIFO read port (see uart_rx_fifo_param_if)
module uart_rx_fifo_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int LOG_DEPTH   = 4,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx,
  input  logic                 clear_err,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic [2:0]           dbg_state_o,
  uart_rx_fifo_param_if.slave  host
);
  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam int SW    = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_HALF      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST      = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    B_LAST      = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST   = 1'(STOP_BITS - 1);
  localparam logic          ODD_PARITY  = (PARITY_MODE == 2);
  localparam logic          HAS_PARITY  = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;

  // Two-stage synchroniser, preset to the idle level.
  logic rx_meta_q, rx_s_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_t               state_q;
  logic                 armed_q;
  logic [SW-1:0]        os_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 stop_q;
  logic                 stop_low_q;
  logic                 wr_en_q;
  logic [DATA_BITS-1:0] wr_data_q;
  logic                 brk_evt_q, frm_evt_q, par_evt_q;

  // A start edge is only accepted once the line has been seen high in IDLE,
  // so a line held low after a break cannot retrigger the receiver.
  logic start_go;
  assign start_go = (state_q == IDLE) && armed_q && !rx_s_q;

  // Tick generator. The divisor is latched at each wrap so a new baud_div
  // never truncates a running period; leaving IDLE realigns the phase.
  logic [DIV_WIDTH-1:0] cnt_q, div_q;
  logic                 tick;
  assign tick = (cnt_q == div_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (start_go || tick) begin
      cnt_q <= '0;
      div_q <= baud_div;
    end else begin
      cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

  // Frame evaluation at the final stop sample.
  logic stop_low_now, is_break, par_bad;
  assign stop_low_now = stop_low_q | ~rx_s_q;
  assign is_break     = (shift_q == '0) && (!HAS_PARITY || !par_q) && stop_low_now;
  assign par_bad      = HAS_PARITY && ((^shift_q) ^ par_q ^ ODD_PARITY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      os_q       <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      stop_low_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      brk_evt_q  <= 1'b0;
      frm_evt_q  <= 1'b0;
      par_evt_q  <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      brk_evt_q <= 1'b0;
      frm_evt_q <= 1'b0;
      par_evt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_s_q) armed_q <= 1'b1;
          if (start_go) begin
            state_q <= START;
            armed_q <= 1'b0;
            os_q    <= '0;
          end
        end
        START: if (tick) begin
          if (os_q == S_HALF) begin
            if (rx_s_q) begin
              state_q <= IDLE;  // glitch shorter than half a bit
            end else begin
              state_q <= DATA;
              os_q    <= '0;
              bit_q   <= '0;
            end
          end else begin
            os_q <= os_q + SW'(1);
          end
        end
        DATA: if (tick) begin
          if (os_q == S_LAST) begin
            os_q    <= '0;
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == B_LAST) begin
              bit_q      <= '0;
              stop_q     <= 1'b0;
              stop_low_q <= 1'b0;
              state_q    <= HAS_PARITY ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            os_q <= os_q + SW'(1);
          end
        end
        PARITY: if (tick) begin
          if (os_q == S_LAST) begin
            os_q    <= '0;
            par_q   <= rx_s_q;
            state_q <= STOP;
          end else begin
            os_q <= os_q + SW'(1);
          end
        end
        STOP: if (tick) begin
          if (os_q == S_LAST) begin
            os_q <= '0;
            if (stop_q == STOP_LAST) begin
              state_q <= IDLE;
              if (is_break)          brk_evt_q <= 1'b1;
              else if (stop_low_now) frm_evt_q <= 1'b1;
              else if (par_bad)      par_evt_q <= 1'b1;
              else begin
                wr_en_q   <= 1'b1;
                wr_data_q <= shift_q;
              end
            end else begin
              stop_q     <= stop_q + 1'b1;
              stop_low_q <= stop_low_now;
            end
          end else begin
            os_q <= os_q + SW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

  // Receive FIFO; the extra pointer bit distinguishes full from empty.
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [LOG_DEPTH:0]   wr_ptr_q, rd_ptr_q;
  logic                 empty, full, pop, push, overrun_evt;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                       (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
  assign pop         = host.read_req && !empty;
  // A pop frees the slot in the same cycle, so a write into a full FIFO
  // still succeeds when it coincides with a read.
  assign push        = wr_en_q && (!full || pop);
  assign overrun_evt = wr_en_q && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= wr_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (LOG_DEPTH+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (LOG_DEPTH+1)'(1);
    end
  end

  assign host.rx_fifo_capacity = wr_ptr_q - rd_ptr_q;
  assign host.rx_empty         = empty;
  assign host.rx_full          = full;
  assign host.read_data        = empty ? '0 : mem_q[rd_ptr_q[LOG_DEPTH-1:0]];

  // Sticky flags: a new event overrides a coincident clear.
  logic frame_err_q, parity_err_q, overrun_err_q, break_det_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      break_det_q   <= 1'b0;
    end else begin
      frame_err_q   <= frm_evt_q   || (frame_err_q   && !clear_err);
      parity_err_q  <= par_evt_q   || (parity_err_q  && !clear_err);
      overrun_err_q <= overrun_evt || (overrun_err_q && !clear_err);
      break_det_q   <= brk_evt_q   || (break_det_q   && !clear_err);
    end
  end

  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign break_det   = break_det_q;
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: unit A uses the default 8N1 / 16-deep
// configuration, unit B uses even parity with a 4-deep FIFO.
module tb_uart_rx_fifo_param;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  localparam int BCLK_SLOW = 27 * 16;  // baud_div = 26
  localparam int BCLK      = 4 * 16;   // baud_div = 3

  logic [15:0] baud_div_a, baud_div_b;
  logic        rx_a, rx_b, clear_a, clear_b;
  logic        fe_a, pe_a, oe_a, brk_a, fe_b, pe_b, oe_b, brk_b;
  logic [2:0]  st_a, st_b;

  uart_rx_fifo_param_if #(.DATA_BITS(8), .LOG_DEPTH(4)) if_a ();
  uart_rx_fifo_param_if #(.DATA_BITS(8), .LOG_DEPTH(2)) if_b ();

  uart_rx_fifo_param #(.LOG_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .baud_div(baud_div_a), .rx(rx_a),
    .clear_err(clear_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun_err(oe_a), .break_det(brk_a), .dbg_state_o(st_a), .host(if_a)
  );

  uart_rx_fifo_param #(.PARITY_MODE(1), .LOG_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .baud_div(baud_div_b), .rx(rx_b),
    .clear_err(clear_b), .frame_err(fe_b), .parity_err(pe_b),
    .overrun_err(oe_b), .break_det(brk_b), .dbg_state_o(st_b), .host(if_b)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                            input logic par_bit, input logic stop_val, input int bclk);
    set_rx(sel, 1'b0);
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, data[i]);
      wait_clks(bclk);
    end
    if (has_par) begin
      set_rx(sel, par_bit);
      wait_clks(bclk);
    end
    set_rx(sel, stop_val);
    wait_clks(bclk);
    set_rx(sel, 1'b1);
    wait_clks(bclk);
  endtask

  task automatic pulse_clear(input int sel);
    if (sel == 0) clear_a = 1'b1; else clear_b = 1'b1;
    wait_clks(1);
    clear_a = 1'b0;
    clear_b = 1'b0;
    wait_clks(1);
  endtask

  task automatic pop_a(input string tag);
    logic [7:0] e;
    e = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 8'hxx;
    check(tag, 32'(if_a.read_data), 32'(e));
    if_a.read_req = 1'b1;
    wait_clks(1);
    if_a.read_req = 1'b0;
  endtask

  task automatic pop_b(input string tag);
    logic [7:0] e;
    e = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 8'hxx;
    check(tag, 32'(if_b.read_data), 32'(e));
    if_b.read_req = 1'b1;
    wait_clks(1);
    if_b.read_req = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [7:0] d;
    logic       found, seen_stop;
    reset = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    clear_a = 1'b0; clear_b = 1'b0;
    baud_div_a = 16'd26; baud_div_b = 16'd3;
    if_a.read_req = 1'b0; if_b.read_req = 1'b0;
    wait_clks(3);

    // Reset state
    check("rst_cap_a",   32'(if_a.rx_fifo_capacity), 32'd0);
    check("rst_empty_a", 32'(if_a.rx_empty), 32'd1);
    check("rst_full_a",  32'(if_a.rx_full), 32'd0);
    check("rst_data_a",  32'(if_a.read_data), 32'd0);
    check("rst_flags_a", {28'd0, fe_a, pe_a, oe_a, brk_a}, 32'd0);
    check("rst_flags_b", {28'd0, fe_b, pe_b, oe_b, brk_b}, 32'd0);
    check("rst_state_a", 32'(st_a), 32'd0);
    reset = 1'b1;
    wait_clks(5);

    // 0xA5 8N1 at baud_div = 26
    exp_a_q.push_back(8'hA5);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, BCLK_SLOW);
    check("a5_cap",   32'(if_a.rx_fifo_capacity), 32'd1);
    check("a5_flags", {28'd0, fe_a, pe_a, oe_a, brk_a}, 32'd0);
    pop_a("a5_data");
    check("a5_cap_after",   32'(if_a.rx_fifo_capacity), 32'd0);
    check("a5_empty_after", 32'(if_a.rx_empty), 32'd1);
    baud_div_a = 16'd3;
    wait_clks(100);

    // Even-parity unit: 0x03 with parity bit 1 is a mismatch
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, BCLK);
    check("par_err",  32'(pe_b), 32'd1);
    check("par_cap",  32'(if_b.rx_fifo_capacity), 32'd0);
    pulse_clear(1);
    check("par_clear", 32'(pe_b), 32'd0);

    // 0x55 with stop bit low
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, BCLK);
    check("frm_err", 32'(fe_a), 32'd1);
    check("frm_cap", 32'(if_a.rx_fifo_capacity), 32'd0);
    check("frm_brk", 32'(brk_a), 32'd0);
    pulse_clear(0);
    check("frm_clear", 32'(fe_a), 32'd0);

    // Break: line low for two frames
    set_rx(0, 1'b0);
    wait_clks(20 * BCLK);
    check("brk_det",   32'(brk_a), 32'd1);
    check("brk_fe",    32'(fe_a), 32'd0);
    check("brk_cap",   32'(if_a.rx_fifo_capacity), 32'd0);
    check("brk_state", 32'(st_a), 32'd0);
    set_rx(0, 1'b1);
    wait_clks(2 * BCLK);
    exp_a_q.push_back(8'h12);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, BCLK);
    check("post_brk_cap", 32'(if_a.rx_fifo_capacity), 32'd1);
    pop_a("post_brk_data");
    check("brk_sticky", 32'(brk_a), 32'd1);

    // Overrun on the 4-deep unit: bytes 0x01..0x05
    for (int b = 1; b <= 5; b++) begin
      d = 8'(b);
      if (b <= 4) exp_b_q.push_back(d);
      send_frame(1, d, 1'b1, ^d, 1'b1, BCLK);
    end
    check("ovr_full", 32'(if_b.rx_full), 32'd1);
    check("ovr_cap",  32'(if_b.rx_fifo_capacity), 32'd4);
    check("ovr_err",  32'(oe_b), 32'd1);
    for (int k = 0; k < 4; k++) pop_b("ovr_data");
    check("ovr_empty", 32'(if_b.rx_empty), 32'd1);
    pulse_clear(1);
    check("ovr_clear", 32'(oe_b), 32'd0);

    // Full FIFO: read coincides with the write of 0x15
    for (int b = 8'h11; b <= 8'h14; b++) begin
      d = 8'(b);
      exp_b_q.push_back(d);
      send_frame(1, d, 1'b1, ^d, 1'b1, BCLK);
    end
    check("sim_full_before", 32'(if_b.rx_full), 32'd1);
    exp_b_q.push_back(8'h15);
    found = 1'b0;
    seen_stop = 1'b0;
    fork
      send_frame(1, 8'h15, 1'b1, ^8'h15, 1'b1, BCLK);
      begin
        for (int n = 0; n < 4000 && !found; n++) begin
          @(negedge clk);
          if (st_b == 3'd4) seen_stop = 1'b1;
          else if (seen_stop && st_b == 3'd0) found = 1'b1;
        end
        if (found) pop_b("sim_pop_data");
      end
    join
    check("sim_found", 32'(found), 32'd1);
    check("sim_cap",   32'(if_b.rx_fifo_capacity), 32'd4);
    check("sim_ovr",   32'(oe_b), 32'd0);
    for (int k = 0; k < 4; k++) pop_b("sim_order");
    check("sim_empty", 32'(if_b.rx_empty), 32'd1);

    // Glitch of 3 ticks on the start bit
    set_rx(0, 1'b0);
    wait_clks(8);
    check("glitch_start", 32'(st_a), 32'd1);
    wait_clks(4);
    set_rx(0, 1'b1);
    wait_clks(60);
    check("glitch_idle", 32'(st_a), 32'd0);
    check("glitch_cap",  32'(if_a.rx_fifo_capacity), 32'd0);

    // Reset mid-DATA with one byte held and break_det still set
    exp_a_q.push_back(8'h7E);
    send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, BCLK);
    check("pre_rst_cap", 32'(if_a.rx_fifo_capacity), 32'd1);
    set_rx(0, 1'b0); wait_clks(BCLK);
    set_rx(0, 1'b1); wait_clks(BCLK);
    set_rx(0, 1'b0); wait_clks(BCLK);
    check("mid_data_state", 32'(st_a), 32'd2);
    reset = 1'b0;
    wait_clks(2);
    exp_a_q.delete();
    check("mid_rst_cap",   32'(if_a.rx_fifo_capacity), 32'd0);
    check("mid_rst_empty", 32'(if_a.rx_empty), 32'd1);
    check("mid_rst_data",  32'(if_a.read_data), 32'd0);
    check("mid_rst_state", 32'(st_a), 32'd0);
    check("mid_rst_flags", {28'd0, fe_a, pe_a, oe_a, brk_a}, 32'd0);
    set_rx(0, 1'b1);
    reset = 1'b1;
    wait_clks(20);
    exp_a_q.push_back(8'h3C);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, BCLK);
    check("post_rst_cap", 32'(if_a.rx_fifo_capacity), 32'd1);
    pop_a("post_rst_data");
    check("post_rst_empty", 32'(if_a.rx_empty), 32'd1);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
